// File: rtl/kamacore_muldiv_sequencer_if.sv
// ---------------------------------------------------------------------------
// kamacore_muldiv_sequencer_if
// Bundles the execute-stage request and the result/stall signals of the
// RV32M multiply/divide sequencer.
//   master : pipeline side. Drives start, funct3, rs1_data, rs2_data and
//            flush. Receives stall, busy, result_valid and result.
//   slave  : sequencer side. The same signals with the directions reversed.
// ---------------------------------------------------------------------------
interface kamacore_muldiv_sequencer_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 start;
  logic [2:0]           funct3;
  logic [CPU_WIDTH-1:0] rs1_data;
  logic [CPU_WIDTH-1:0] rs2_data;
  logic                 flush;
  logic                 stall;
  logic                 busy;
  logic                 result_valid;
  logic [CPU_WIDTH-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  stall, busy, result_valid, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output stall, busy, result_valid, result
  );
endinterface

// File: rtl/kamacore_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// kamacore_muldiv_sequencer
// Multi-cycle RV32M multiply/divide controller for the execute stage.
// Captures operands on start, then runs a shift-add multiply or a restoring
// divide at one bit per cycle for CPU_WIDTH cycles while it holds the
// pipeline. It then presents one result_valid cycle. Divide by zero and
// signed overflow finish in one cycle.
//   clk : rising-edge clock
//   rst : synchronous reset, active-high
//   bus : slave modport. Inputs are start, funct3, rs1_data, rs2_data and
//         flush. Outputs are stall, busy, result_valid and result.
// ---------------------------------------------------------------------------
module kamacore_muldiv_sequencer #(
  parameter int CPU_WIDTH = 32
) (
  input logic                        clk,
  input logic                        rst,
  kamacore_muldiv_sequencer_if.slave bus
);
  localparam int W  = CPU_WIDTH;
  localparam int CW = $clog2(CPU_WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [CW-1:0] CNT_LAST = CW'(CPU_WIDTH - 1);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d;     // sign to apply to the selected result
  logic [W-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*W-1:0] acc_q, acc_d;     // {product} or {remainder, quotient}
  logic [W-1:0]   result_q, result_d;

  // Operand conditioning at issue time
  logic         signed_a, signed_b, neg1, neg2, sign_in, fast;
  logic [W-1:0] a_mag, b_mag, fast_result;

  assign signed_a = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_MULHSU) ||
                    (bus.funct3 == OP_DIV)  || (bus.funct3 == OP_REM);
  assign signed_b = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_DIV) ||
                    (bus.funct3 == OP_REM);
  assign neg1     = signed_a & bus.rs1_data[W-1];
  assign neg2     = signed_b & bus.rs2_data[W-1];
  assign a_mag    = neg1 ? -bus.rs1_data : bus.rs1_data;
  assign b_mag    = neg2 ? -bus.rs2_data : bus.rs2_data;
  // A remainder follows the dividend. A quotient or product follows both signs.
  assign sign_in  = (bus.funct3 == OP_REM) ? neg1 : (neg1 ^ neg2);

  // Divide by zero, and the signed MIN_NEG / -1 overflow, bypass CALC
  logic div_zero, div_ovf;
  assign div_zero    = (bus.rs2_data == '0);
  assign div_ovf     = !bus.funct3[0] && (bus.rs1_data == MIN_NEG) &&
                       (bus.rs2_data == '1);
  assign fast        = bus.funct3[2] && (div_zero || div_ovf);
  assign fast_result = div_zero ? (bus.funct3[1] ? bus.rs1_data : '1)
                                : (bus.funct3[1] ? '0 : bus.rs1_data);

  // One multiply step: add the multiplicand when the multiplier LSB is 1, then shift right
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_step, prod_fix;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
  assign prod_fix = neg_q ? -mul_step : mul_step;

  // One restoring divide step: shift in the next dividend bit, then subtract when it fits
  logic [W:0]     rem_sh, div_diff;
  logic [2*W-1:0] div_step;
  logic [W-1:0]   quo_fix, rem_fix;
  assign rem_sh   = acc_q[2*W-1:W-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign div_step = div_diff[W] ? {rem_sh[W-1:0], acc_q[W-2:0], 1'b0}
                                : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
  assign quo_fix  = neg_q ? -div_step[W-1:0]   : div_step[W-1:0];
  assign rem_fix  = neg_q ? -div_step[2*W-1:W] : div_step[2*W-1:W];

  logic [W-1:0] calc_result;
  assign calc_result = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                     : ((op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W]);

  always_comb begin
    // NOTE: each next-state variable starts from its current value, so every
    // path assigns it and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.funct3;
          neg_d = sign_in;
          cnt_d = CNT_LAST;
          if (bus.funct3[2]) begin
            opnd_d = b_mag;
            acc_d  = {{W{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{W{1'b0}}, b_mag};
          end
          if (fast) begin
            result_d = fast_result;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_step : mul_step;
        if (cnt_q == '0) begin
          result_d = calc_result;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush aborts the operation without writing a result
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // NOTE: the datapath registers are always loaded before they are read, so
  // they have no reset.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg_q  <= neg_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;
  assign bus.stall        = ((state_q == IDLE) && bus.start && !bus.flush) ||
                            (state_q == CALC);
endmodule

// File: tb/tb_kamacore_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kamacore_muldiv_sequencer
// Bench for kamacore_muldiv_sequencer. A behavioural model uses plain 64-bit
// arithmetic and a countdown of remaining busy cycles. One process compares
// it with the DUT on every falling edge. Directed cases pin literal results
// and latencies. A randomized phase mixes start, flush and rst.
// ---------------------------------------------------------------------------
module tb_kamacore_muldiv_sequencer;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kamacore_muldiv_sequencer_if #(.CPU_WIDTH(W)) bus ();
  kamacore_muldiv_sequencer #(.CPU_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'b0, a};
    logic [63:0] ub = {32'b0, b};
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
  endfunction

  // left = cycles still busy, counting the current one. The valid cycle is left==1.
  int          left     = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;

  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      m_result = '0;
    end else if (bus.flush) begin
      left = 0;
    end else if (left > 0) begin
      left = left - 1;
    end else if (bus.start) begin
      m_pending = ref_op(bus.funct3, bus.rs1_data, bus.rs2_data);
      left = ref_fast(bus.funct3, bus.rs1_data, bus.rs2_data) ? 1 : W + 1;
      if (left == 1) m_result = m_pending;
    end
    if (!rst && !bus.flush && left == 1) m_result = m_pending;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(bus.busy), 32'(left > 0));
      check("valid",  32'(bus.result_valid), 32'(left == 1));
      check("stall",  32'(bus.stall),
            32'((left == 0 && bus.start && !bus.flush) || left > 1));
      check("result", bus.result, m_result);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = f; bus.rs1_data = a; bus.rs2_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.result_valid) begin lat = c; break; end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_result"}, bus.result, exp);
    @(negedge clk);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_NEG;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int valids;
    int lat;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_valid",  32'(bus.result_valid), 32'd0);
    check("reset_stall",  32'(bus.stall), 32'd0);
    check("reset_result", bus.result, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    run_op("mul",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulhu",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulh",     3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("mulhsu",   3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("div",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    run_op("rem",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    run_op("div_zero", 3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_zero",3'd7, 32'd5,          32'd0,         32'd5,         1);
    run_op("div_ovf",  3'd4, MIN_NEG,        32'hFFFF_FFFF, MIN_NEG,       1);
    run_op("rem_ovf",  3'd6, MIN_NEG,        32'hFFFF_FFFF, 32'd0,         1);
    run_op("remu",     3'd7, 32'd100,        32'd7,         32'd2,         33);
    run_op("divu",     3'd5, 32'd100,        32'd7,         32'd14,        33);

    // Flush on cycle 10 of a DIVU, then a new start on cycle 11
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.rs1_data = 32'd1000; bus.rs2_data = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    check("flush_busy",   32'(bus.busy), 32'd0);
    check("flush_result", bus.result, 32'd14);
    @(posedge clk); #1 bus.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.result_valid) begin lat = c; break; end
    end
    check("after_flush_latency", 32'(lat), 32'd33);
    check("after_flush_result",  bus.result, 32'd333);

    // Reset on cycle 15 of a MUL
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",   32'(bus.busy), 32'd0);
    check("rst_mid_stall",  32'(bus.stall), 32'd0);
    check("rst_mid_valid",  32'(bus.result_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);

    // A start during CALC is ignored and produces no second result
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13;
    valids = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (bus.result_valid) valids++;
      @(posedge clk); #1;
      bus.start = (c == 4);
    end
    check("ignored_start_valids", 32'(valids), 32'd1);
    check("ignored_start_result", bus.result, 32'd15);

    // Randomized traffic
    for (int cyc = 0; cyc < 12000; cyc++) begin
      @(posedge clk); #1;
      bus.start    = ($urandom_range(0, 3) == 0);
      bus.flush    = ($urandom_range(0, 79) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      bus.funct3   = 3'($urandom_range(0, 7));
      bus.rs1_data = pick();
      bus.rs2_data = pick();
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
